// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout and flit construction helper.
package noc_pkg;

  localparam int unsigned FLIT_W        = 39;
  localparam int unsigned FLIT_DEST_LSB = 33;
  localparam int unsigned FLIT_DEST_W   = 4;
  localparam int unsigned FLIT_DATA_W   = 32;

  // Single-flit packet: head and tail markers set, reserved bit clear.
  typedef struct packed {
    logic                   head;
    logic                   tail;
    logic [FLIT_DEST_W-1:0] dest;
    logic                   rsvd;
    logic [FLIT_DATA_W-1:0] data;
  } flit_t;

  // Build a single-flit packet for the given destination and payload.
  function automatic flit_t make_flit(input logic [FLIT_DEST_W-1:0] dest,
                                      input logic [FLIT_DATA_W-1:0] data);
    flit_t f;
    f.head = 1'b1;
    f.tail = 1'b1;
    f.dest = dest;
    f.rsvd = 1'b0;
    f.data = data;
    return f;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after i_ptr wins.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    i_req,
  input  logic [IdxW-1:0] i_ptr,
  output logic [N-1:0]    o_gnt,
  output logic [IdxW-1:0] o_gnt_idx
);

  logic w_found;

  // Scan requesters starting at the pointer, wrapping once around.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!w_found && i_req[IdxW'((32'(i_ptr) + i) % N)]) begin
        w_found                           = 1'b1;
        o_gnt[IdxW'((32'(i_ptr) + i) % N)] = 1'b1;
        o_gnt_idx                         = IdxW'((32'(i_ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/pe_inject_arbiter.sv
// Shares one router injection port between NUM_REQ sources; each accepted
// request becomes a timestamped single-flit packet, with per-source quotas.
module pe_inject_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned AddressWidth = 4,
  parameter int unsigned PktLmit      = 20,
  parameter int unsigned CntWidth     = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_start,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  input  logic [NUM_REQ*AddressWidth-1:0] i_req_dest,
  output logic [NUM_REQ-1:0]              o_req_ready,
  output logic [FLIT_W-1:0]               o_data,
  output logic                            o_data_valid,
  input  logic                            i_data_ready,
  output logic [NUM_REQ*16-1:0]           o_sent,
  output logic                            o_done
);

  localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SentW  = 16;
  localparam logic        LIMITED = (PktLmit != 0);

  logic [CntWidth-1:0]      r_cnt;
  logic [IdxW-1:0]          r_ptr;
  logic [NUM_REQ*SentW-1:0] r_sent;
  logic                     r_valid;
  logic [FLIT_W-1:0]        r_data;
  logic                     r_done;
  logic                     r_seen;

  logic [NUM_REQ-1:0]      w_exh;
  logic [NUM_REQ-1:0]      w_elig;
  logic [NUM_REQ-1:0]      w_gnt;
  logic [IdxW-1:0]         w_gnt_idx;
  logic                    w_slot_free;
  logic                    w_grant;
  logic                    w_valid_next;
  logic                    w_done_set;
  logic [AddressWidth-1:0] w_dest;
  logic [IdxW-1:0]         w_ptr_next;

  // Quota status per requester; unlimited mode never exhausts.
  always_comb begin
    w_exh = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_exh[k] = LIMITED && (r_sent[k*SentW +: SentW] == SentW'(PktLmit));
    end
  end

  assign w_elig      = {NUM_REQ{i_start}} & i_req_valid & ~w_exh;
  assign w_slot_free = !r_valid || i_data_ready;
  assign w_grant     = w_slot_free && (|w_elig);

  rr_arbiter #(
    .N    (NUM_REQ),
    .IdxW (IdxW)
  ) u_rr (
    .i_req     (w_elig),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  assign o_req_ready = w_grant ? w_gnt : '0;

  // Winner's destination, next pointer, slot occupancy and done condition.
  always_comb begin
    w_dest       = i_req_dest[32'(w_gnt_idx)*AddressWidth +: AddressWidth];
    w_ptr_next   = (32'(w_gnt_idx) == NUM_REQ - 1) ? '0 : IdxW'(w_gnt_idx + IdxW'(1));
    w_valid_next = w_grant || (r_valid && !i_data_ready);
    w_done_set   = LIMITED && (r_seen || i_start) && (&w_exh) && !w_valid_next;
  end

  // Counter, pointer, quota counters, output slot and done flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_sent  <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_seen  <= 1'b0;
    end else begin
      r_cnt  <= r_cnt + CntWidth'(1);
      r_seen <= r_seen || i_start;
      r_done <= r_done || w_done_set;
      r_valid <= w_valid_next;
      if (w_grant) begin
        r_ptr  <= w_ptr_next;
        r_data <= make_flit(FLIT_DEST_W'(w_dest), FLIT_DATA_W'(r_cnt));
      end
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (w_grant && w_gnt[k] && (r_sent[k*SentW +: SentW] != {SentW{1'b1}})) begin
          r_sent[k*SentW +: SentW] <= r_sent[k*SentW +: SentW] + SentW'(1);
        end
      end
    end
  end

  assign o_data       = r_data;
  assign o_data_valid = r_valid;
  assign o_sent       = r_sent;
  assign o_done       = r_done;

endmodule
